// File: rtl/sst39_pkg.sv
// Shared encodings, command constants and unlock sequence tables for the
// SST39VF200A-style parallel NOR flash bus initiator.
package sst39_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_PROG  = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_SETUP,
        WR_PULSE,
        WR_RECOV,
        POLL_ACC,
        POLL_GAP,
        RESP
    } state_e;

    localparam logic [16:0] UNLOCK_ADDR1 = 17'h05555;
    localparam logic [16:0] UNLOCK_ADDR2 = 17'h02AAA;

    localparam logic [15:0] CMD_AA = 16'h00AA;
    localparam logic [15:0] CMD_55 = 16'h0055;
    localparam logic [15:0] CMD_A0 = 16'h00A0;
    localparam logic [15:0] CMD_80 = 16'h0080;
    localparam logic [15:0] CMD_10 = 16'h0010;

    localparam int PROG_LEN  = 4;
    localparam int ERASE_LEN = 6;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
    } bus_word_t;

    localparam bus_word_t BW_NONE = '0;

    // Entry 3 of the program sequence comes from the host address/data, supplied by seq_word.
    localparam bus_word_t [0:7] PROG_SEQ = {
        bus_word_t'({UNLOCK_ADDR1, CMD_AA}),
        bus_word_t'({UNLOCK_ADDR2, CMD_55}),
        bus_word_t'({UNLOCK_ADDR1, CMD_A0}),
        BW_NONE, BW_NONE, BW_NONE, BW_NONE, BW_NONE
    };

    localparam bus_word_t [0:7] ERASE_SEQ = {
        bus_word_t'({UNLOCK_ADDR1, CMD_AA}),
        bus_word_t'({UNLOCK_ADDR2, CMD_55}),
        bus_word_t'({UNLOCK_ADDR1, CMD_80}),
        bus_word_t'({UNLOCK_ADDR1, CMD_AA}),
        bus_word_t'({UNLOCK_ADDR2, CMD_55}),
        bus_word_t'({UNLOCK_ADDR1, CMD_10}),
        BW_NONE, BW_NONE
    };

    // Address/data word for step idx of the command sequence belonging to op.
    function automatic bus_word_t seq_word(input op_e op, input logic [2:0] idx,
                                           input logic [16:0] a, input logic [15:0] d);
        bus_word_t w;
        if (op == OP_PROG) begin
            if (idx == 3'd3) begin
                w.addr = a;
                w.data = d;
            end else begin
                w = PROG_SEQ[idx];
            end
        end else begin
            w = ERASE_SEQ[idx];
        end
        return w;
    endfunction

    // Index of the final word of the command sequence belonging to op.
    function automatic logic [2:0] seq_last(input op_e op);
        return (op == OP_PROG) ? 3'(PROG_LEN - 1) : 3'(ERASE_LEN - 1);
    endfunction

endpackage

// File: rtl/sst39_flash_ctrl.sv
// Single-word host request to SST39VF200A flash bus cycle converter:
// read, JEDEC word-program and chip-erase with Data# polling on DQ7.
module sst39_flash_ctrl
    import sst39_pkg::*;
#(
    parameter int T_RD     = 3,
    parameter int T_WP     = 2,
    parameter int T_WPH    = 1,
    parameter int POLL_MAX = 4096
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [16:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [16:0] flash_addr,
    output logic [15:0] flash_dq_o,
    output logic        flash_dq_oe,
    input  logic [15:0] flash_dq_i,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n
);

    localparam logic [7:0]  RD_INIT   = 8'(T_RD - 1);
    localparam logic [7:0]  WP_INIT   = 8'(T_WP - 1);
    localparam logic [7:0]  WPH_INIT  = 8'(T_WPH - 1);
    localparam logic [12:0] POLL_LAST = 13'(POLL_MAX - 1);

    state_e      state;
    op_e         op_q;
    logic [16:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0]  seq_idx;
    logic [7:0]  tcnt;
    logic [12:0] poll_cnt;
    logic        poll_expect;

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign poll_expect = (op_q == OP_PROG) ? wdata_q[7] : 1'b1;

    // Bus sequencing FSM: every strobe and response output is a register set on the transition into the state that needs it.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            seq_idx     <= '0;
            tcnt        <= '0;
            poll_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            flash_addr  <= '0;
            flash_dq_o  <= '0;
            flash_dq_oe <= 1'b0;
            flash_ce_n  <= 1'b1;
            flash_oe_n  <= 1'b1;
            flash_we_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= op_e'(req_op);
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        seq_idx  <= '0;
                        poll_cnt <= '0;
                        case (op_e'(req_op))
                            OP_READ: begin
                                state      <= RD_ACC;
                                flash_addr <= req_addr;
                                flash_ce_n <= 1'b0;
                                flash_oe_n <= 1'b0;
                                tcnt       <= RD_INIT;
                            end
                            OP_PROG, OP_ERASE: begin
                                state       <= WR_SETUP;
                                flash_ce_n  <= 1'b0;
                                flash_dq_oe <= 1'b1;
                                {flash_addr, flash_dq_o} <=
                                    seq_word(op_e'(req_op), 3'd0, req_addr, req_wdata);
                            end
                            default: begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_ACC: begin
                    if (tcnt == 8'd0) begin
                        state      <= RESP;
                        rsp_rdata  <= flash_dq_i;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b0;
                        flash_ce_n <= 1'b1;
                        flash_oe_n <= 1'b1;
                    end else begin
                        tcnt <= tcnt - 8'd1;
                    end
                end
                WR_SETUP: begin
                    state      <= WR_PULSE;
                    flash_we_n <= 1'b0;
                    tcnt       <= WP_INIT;
                end
                WR_PULSE: begin
                    if (tcnt == 8'd0) begin
                        state      <= WR_RECOV;
                        flash_ce_n <= 1'b1;
                        flash_we_n <= 1'b1;
                        tcnt       <= WPH_INIT;
                    end else begin
                        tcnt <= tcnt - 8'd1;
                    end
                end
                WR_RECOV: begin
                    if (tcnt != 8'd0) begin
                        tcnt <= tcnt - 8'd1;
                    end else if (seq_idx == seq_last(op_q)) begin
                        state       <= POLL_GAP;
                        flash_dq_oe <= 1'b0;
                        flash_dq_o  <= '0;
                        flash_addr  <= (op_q == OP_PROG) ? addr_q : 17'd0;
                    end else begin
                        state      <= WR_SETUP;
                        seq_idx    <= seq_idx + 3'd1;
                        flash_ce_n <= 1'b0;
                        {flash_addr, flash_dq_o} <=
                            seq_word(op_q, seq_idx + 3'd1, addr_q, wdata_q);
                    end
                end
                POLL_GAP: begin
                    state      <= POLL_ACC;
                    flash_ce_n <= 1'b0;
                    flash_oe_n <= 1'b0;
                    tcnt       <= RD_INIT;
                end
                POLL_ACC: begin
                    if (tcnt != 8'd0) begin
                        tcnt <= tcnt - 8'd1;
                    end else begin
                        flash_ce_n <= 1'b1;
                        flash_oe_n <= 1'b1;
                        rsp_rdata  <= flash_dq_i;
                        if (flash_dq_i[7] == poll_expect) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                        end else if (poll_cnt == POLL_LAST) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state    <= POLL_GAP;
                            poll_cnt <= poll_cnt + 13'd1;
                        end
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sst39_flash_ctrl.sv
// Bench for sst39_flash_ctrl paired with a behavioural program/erase-capable
// flash model; table-driven operations plus reset, timeout and handshake sequences.
module tb_sst39_flash_ctrl;

    localparam int POLL_MAX = 16;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [16:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [16:0] flash_addr;
    logic [15:0] flash_dq_o;
    logic        flash_dq_oe;
    logic [15:0] flash_dq_i;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;

    sst39_flash_ctrl #(
        .T_RD(3), .T_WP(2), .T_WPH(1), .POLL_MAX(POLL_MAX)
    ) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
        .flash_dq_i(flash_dq_i), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
        .flash_we_n(flash_we_n)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    typedef struct {
        logic [16:0] a;
        logic [15:0] d;
        int          wl;
    } wr_t;

    // Flash model state, owned by the monitor process.
    logic [15:0] mem [0:131071];
    bit          inited = 0;
    int          busyLeft = 0;
    logic [15:0] statusWord = 16'h0000;
    int          step = 0;
    int          progCount = 0;
    int          eraseCount = 0;
    int          readCount = 0;
    int          ceLowCnt = 0;
    int          overlapBad = 0;
    int          addrBad = 0;
    int          rspBothBad = 0;
    int          rspCount = 0;
    int          wlCur = 0;
    bit          prevWe = 0;
    bit          prevRead = 0;
    bit          prevDqOe = 0;
    logic [16:0] latA = '0;
    logic [15:0] latD = '0;
    wr_t         wlog[$];

    // Model configuration, owned by the stimulus process.
    int          progBusyPolls = 0;
    int          eraseBusyPolls = 0;
    logic [16:0] expPollAddr = '0;

    int nCompared = 0;
    int nMismatched = 0;

    assign flash_dq_i = (busyLeft > 0) ? statusWord : mem[flash_addr];

    // JEDEC command decoder applied to each completed write cycle.
    task automatic modelCommit(input logic [16:0] a, input logic [15:0] d);
        int s;
        s = step;
        case (step)
            0: step = (a == 17'h05555 && d == 16'h00AA) ? 1 : 0;
            1: step = (a == 17'h02AAA && d == 16'h0055) ? 2 : 0;
            2: if (a == 17'h05555 && d == 16'h00A0) step = 3;
               else if (a == 17'h05555 && d == 16'h0080) step = 4;
               else step = 0;
            3: begin
                mem[a] = mem[a] & d;
                statusWord = d ^ 16'h0080;
                busyLeft = progBusyPolls;
                progCount++;
                step = 0;
            end
            4: step = (a == 17'h05555 && d == 16'h00AA) ? 5 : 0;
            5: step = (a == 17'h02AAA && d == 16'h0055) ? 6 : 0;
            6: begin
                if (a == 17'h05555 && d == 16'h0010) begin
                    for (int i = 0; i < 131072; i++) mem[i] = 16'hFFFF;
                    statusWord = 16'h0000;
                    busyLeft = eraseBusyPolls;
                    eraseCount++;
                end
                step = 0;
            end
            default: step = 0;
        endcase
        if (s != 0 && s != 3 && step == 0 && a == 17'h05555 && d == 16'h00AA) step = 1;
    endtask

    // Bus monitor and flash model, evaluated mid-cycle.
    always @(negedge SIM_CLK) begin
        bit wrNow;
        bit rdNow;
        if (!inited) begin
            for (int i = 0; i < 131072; i++) mem[i] = 16'hFFFF;
            mem[17'h00123] = 16'h1234;
            inited = 1;
        end
        if (!flash_ce_n) ceLowCnt++;
        if (!flash_oe_n && (flash_dq_oe || prevDqOe)) overlapBad++;
        if (!flash_ce_n && !flash_oe_n && flash_addr != expPollAddr) addrBad++;
        if (req_ready && rsp_valid) rspBothBad++;
        if (rsp_valid) rspCount++;
        wrNow = !flash_ce_n && !flash_we_n;
        if (wrNow) begin
            if (!flash_dq_oe) overlapBad++;
            latA = flash_addr;
            latD = flash_dq_o;
            wlCur++;
        end else if (prevWe) begin
            wlog.push_back('{latA, latD, wlCur});
            modelCommit(latA, latD);
            wlCur = 0;
        end
        rdNow = !flash_ce_n && !flash_oe_n;
        if (prevRead && !rdNow) begin
            readCount++;
            if (busyLeft > 0) busyLeft--;
        end
        prevWe = wrNow;
        prevRead = rdNow;
        prevDqOe = flash_dq_oe;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected command sequence words, written out independently of the design tables.
    function automatic logic [32:0] expWr(input logic [1:0] op, input int j,
                                          input logic [16:0] a, input logic [15:0] d);
        if (op == 2'b01) begin
            case (j)
                0: return {17'h05555, 16'h00AA};
                1: return {17'h02AAA, 16'h0055};
                2: return {17'h05555, 16'h00A0};
                default: return {a, d};
            endcase
        end
        case (j)
            0: return {17'h05555, 16'h00AA};
            1: return {17'h02AAA, 16'h0055};
            2: return {17'h05555, 16'h0080};
            3: return {17'h05555, 16'h00AA};
            4: return {17'h02AAA, 16'h0055};
            default: return {17'h05555, 16'h0010};
        endcase
    endfunction

    task automatic waitReady();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge SIM_CLK); #2;
            n++;
        end
    endtask

    // Issue one request and wait for its response; lat counts cycles from the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [16:0] addr,
                                 input logic [15:0] wdata, output int lat,
                                 output logic [15:0] rdata, output logic err,
                                 output logic timedOut);
        waitReady();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge SIM_CLK); #2;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 5000) begin
            @(posedge SIM_CLK); #2;
            lat++;
        end
        timedOut = !rsp_valid;
        rdata    = rsp_rdata;
        err      = rsp_err;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [16:0] addr;
        logic [15:0] wdata;
        int          busyPolls;
        bit          chkData;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          nWr;
        int          nRd;
        int          ceLow;
    } vec_t;

    vec_t vec[9];

    initial begin
        int          lat;
        logic [15:0] rdata;
        logic        err;
        logic        timedOut;
        int          w0, r0, c0, p0, s0, n;

        SIM_RST   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;

        // Latency: read 3+1; program/erase 4 cycles per command word + 4 per poll read + 1.
        vec[0] = '{2'b00, 17'h00123, 16'h0000, 0, 1, 16'h1234, 1'b0, 4, 0, 1, 3};
        vec[1] = '{2'b01, 17'h01000, 16'hBEEF, 5, 1, 16'hBEEF, 1'b0, 41, 4, 6, -1};
        vec[2] = '{2'b00, 17'h01000, 16'h0000, 0, 1, 16'hBEEF, 1'b0, 4, 0, 1, 3};
        vec[3] = '{2'b01, 17'h00050, 16'h0123, 0, 1, 16'h0123, 1'b0, 21, 4, 1, -1};
        vec[4] = '{2'b00, 17'h00050, 16'h0000, 0, 1, 16'h0123, 1'b0, 4, 0, 1, 3};
        vec[5] = '{2'b10, 17'h00000, 16'h0000, 3, 1, 16'hFFFF, 1'b0, 41, 6, 4, -1};
        vec[6] = '{2'b00, 17'h1FFFF, 16'h0000, 0, 1, 16'hFFFF, 1'b0, 4, 0, 1, 3};
        vec[7] = '{2'b00, 17'h01000, 16'h0000, 0, 1, 16'hFFFF, 1'b0, 4, 0, 1, 3};
        vec[8] = '{2'b11, 17'h00123, 16'h5555, 0, 0, 16'h0000, 1'b1, 1, 0, 0, 0};

        // Reset state.
        repeat (2) @(posedge SIM_CLK);
        #2;
        checkOutput("rst_strobes", {flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe}, 4'b1110);
        checkOutput("rst_addr_dq", {flash_addr, flash_dq_o}, 33'd0);
        checkOutput("rst_rsp", {rsp_valid, rsp_err, busy, rsp_rdata}, 19'd0);
        checkOutput("rst_ready", req_ready, 1'b1);
        SIM_RST = 1'b1;
        @(posedge SIM_CLK); #2;

        // Reset asserted in the middle of the first write pulse of a program.
        progBusyPolls = 5;
        p0 = progCount;
        waitReady();
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 17'h00300;
        req_wdata = 16'h1111;
        @(posedge SIM_CLK); #2;
        req_valid = 1'b0;
        n = 0;
        while (flash_we_n && n < 20) begin
            @(posedge SIM_CLK); #2;
            n++;
        end
        checkOutput("mid_we_low", flash_we_n, 1'b0);
        #2;
        SIM_RST = 1'b0;
        #1;
        checkOutput("mid_rst_strobes", {flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe}, 4'b1110);
        checkOutput("mid_rst_busy", busy, 1'b0);
        @(posedge SIM_CLK); #2;
        SIM_RST = 1'b1;
        @(posedge SIM_CLK); #2;
        checkOutput("mid_ready_after", req_ready, 1'b1);
        repeat (3) @(posedge SIM_CLK);
        #2;
        checkOutput("mid_no_program", progCount - p0, 0);

        // Table-driven operations.
        for (int i = 0; i < 9; i++) begin
            progBusyPolls  = vec[i].busyPolls;
            eraseBusyPolls = vec[i].busyPolls;
            expPollAddr    = (vec[i].op == 2'b10) ? 17'd0 : vec[i].addr;
            w0 = wlog.size();
            r0 = readCount;
            c0 = ceLowCnt;
            applyStimulus(vec[i].op, vec[i].addr, vec[i].wdata, lat, rdata, err, timedOut);
            @(posedge SIM_CLK); #2;
            checkOutput($sformatf("v%0d_timeout", i), timedOut, 1'b0);
            checkOutput($sformatf("v%0d_err", i), err, vec[i].err);
            if (vec[i].chkData) checkOutput($sformatf("v%0d_rdata", i), rdata, vec[i].rdata);
            checkOutput($sformatf("v%0d_latency", i), lat, vec[i].lat);
            checkOutput($sformatf("v%0d_nwrites", i), wlog.size() - w0, vec[i].nWr);
            checkOutput($sformatf("v%0d_nreads", i), readCount - r0, vec[i].nRd);
            if (vec[i].ceLow >= 0)
                checkOutput($sformatf("v%0d_ce_low_cycles", i), ceLowCnt - c0, vec[i].ceLow);
            for (int j = 0; j < vec[i].nWr; j++) begin
                if (wlog.size() > w0 + j) begin
                    checkOutput($sformatf("v%0d_wr%0d", i, j),
                                {wlog[w0 + j].a, wlog[w0 + j].d},
                                expWr(vec[i].op, j, vec[i].addr, vec[i].wdata));
                    checkOutput($sformatf("v%0d_wr%0d_we_low", i, j), wlog[w0 + j].wl, 2);
                end
            end
        end

        // Program that never completes within the poll budget, with stray requests while busy.
        progBusyPolls = POLL_MAX;
        expPollAddr   = 17'h00200;
        waitReady();
        r0 = readCount;
        s0 = rspCount;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 17'h00200;
        req_wdata = 16'h5A5A;
        @(posedge SIM_CLK); #2;
        req_op = 2'b00;
        repeat (5) @(posedge SIM_CLK);
        #2;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 5000) begin
            @(posedge SIM_CLK); #2;
            n++;
        end
        checkOutput("stuck_rsp_seen", rsp_valid, 1'b1);
        checkOutput("stuck_err", rsp_err, 1'b1);
        repeat (4) @(posedge SIM_CLK);
        #2;
        checkOutput("stuck_poll_reads", readCount - r0, POLL_MAX);
        checkOutput("stuck_rsp_count", rspCount - s0, 1);
        checkOutput("stuck_ready", req_ready, 1'b1);

        // Reserved op held valid: re-accepted only once the controller is idle again.
        waitReady();
        c0 = ceLowCnt;
        req_valid = 1'b1;
        req_op    = 2'b11;
        @(posedge SIM_CLK); #2;
        checkOutput("rsv_c1", {rsp_valid, rsp_err, req_ready}, 3'b110);
        @(posedge SIM_CLK); #2;
        checkOutput("rsv_c2", {rsp_valid, req_ready}, 2'b01);
        @(posedge SIM_CLK); #2;
        req_valid = 1'b0;
        checkOutput("rsv_c3", {rsp_valid, rsp_err, req_ready}, 3'b110);
        @(posedge SIM_CLK); #2;
        checkOutput("rsv_c4", {rsp_valid, req_ready}, 2'b01);
        checkOutput("rsv_no_strobes", ceLowCnt - c0, 0);

        // Whole-run bus rules.
        checkOutput("dq_oe_oe_overlap", overlapBad, 0);
        checkOutput("read_addr", addrBad, 0);
        checkOutput("ready_with_rsp", rspBothBad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
